data_access: RTL and testbench

//   Memory-access stage directly downstream of the execute stage. Consumes the
//   ALU result as a byte address, read_data2 as store data, and the zero flag.

---
 rtl/data_access.sv | 112 +++++++++++
 tb/tb_data_access.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/data_access.sv
// rtl/data_access.sv - doubleword load/store stage with fixed-latency data memory and branch resolve
module data_access #(
    parameter int WORD      = 64,
    parameter int MEM_DEPTH = 128,
    parameter int LATENCY   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_valid,
    input  logic [WORD-1:0] alu_result,
    input  logic [WORD-1:0] read_data2,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic            branch,
    input  logic            uncond_branch,
    input  logic            zero,
    output logic [WORD-1:0] read_data,
    output logic            pc_src,
    output logic            done,
    output logic            stall,
    output logic            addr_error
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [WORD-1:0] ADDR_LIMIT = WORD'(MEM_DEPTH) << 3;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [WORD-1:0] addr_q;
    logic [WORD-1:0] data_q;
    logic            rd_q;
    logic            wr_q;
    logic            pc_src_q;

    logic [WORD-1:0] mem [MEM_DEPTH];

    logic            access;
    logic            is_op;
    logic            err;
    logic [AW-1:0]   index;

    assign access = (state == BUSY) && (cnt == '0);
    assign is_op  = rd_q | wr_q;
    assign index  = addr_q[3 +: AW];
    // Conflicting op, misalignment and range are all judged on the latched request.
    assign err    = is_op && ((rd_q && wr_q) || (addr_q[2:0] != 3'b000) || (addr_q >= ADDR_LIMIT));

    // Memory is deliberately outside the reset domain; reset only suppresses pending writes via state.
    always_ff @(posedge clk) begin
        if (access && wr_q && !err) begin
            mem[index] <= data_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            pc_src_q   <= 1'b0;
            read_data  <= '0;
            pc_src     <= 1'b0;
            done       <= 1'b0;
            stall      <= 1'b0;
            addr_error <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (mem_valid) begin
                        addr_q   <= alu_result;
                        data_q   <= read_data2;
                        rd_q     <= mem_read;
                        wr_q     <= mem_write;
                        pc_src_q <= uncond_branch | (branch & zero);
                        cnt      <= CW'(LATENCY - 1);
                        stall    <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state      <= DONE;
                        stall      <= 1'b0;
                        done       <= 1'b1;
                        pc_src     <= pc_src_q;
                        addr_error <= err;
                        if (err) begin
                            read_data <= '0;
                        end else if (rd_q) begin
                            read_data <= mem[index];
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_access.sv
// tb/tb_data_access.sv - randomized self-checking bench for data_access against a behavioural model
module tb_data_access;
    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_valid = 1'b0;
    logic [63:0] alu_result = '0;
    logic [63:0] read_data2 = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic        branch = 1'b0;
    logic        uncond_branch = 1'b0;
    logic        zero = 1'b0;
    logic [63:0] read_data;
    logic        pc_src;
    logic        done;
    logic        stall;
    logic        addr_error;

    int passed = 0;
    int total = 0;

    logic [63:0] mem_m [128];
    logic [63:0] rd_exp = '0;

    always #5 clk = ~clk;

    data_access #(.WORD(64), .MEM_DEPTH(128), .LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .mem_valid(mem_valid), .alu_result(alu_result),
        .read_data2(read_data2), .mem_read(mem_read), .mem_write(mem_write),
        .branch(branch), .uncond_branch(uncond_branch), .zero(zero),
        .read_data(read_data), .pc_src(pc_src), .done(done), .stall(stall),
        .addr_error(addr_error)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic [63:0] a, input logic [63:0] d, input logic rd, input logic wr,
                           input logic br, input logic ub, input logic z, input bit hold);
        int   n;
        logic op;
        logic err;
        alu_result = a; read_data2 = d; mem_read = rd; mem_write = wr;
        branch = br; uncond_branch = ub; zero = z; mem_valid = 1'b1;
        @(posedge clk); #1;
        if (!hold) mem_valid = 1'b0;
        check("stall_after_accept", stall, 1);
        check("done_after_accept", done, 0);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (done !== 1'b1) check("stall_busy", stall, 1);
        end
        check("latency", n, LAT);
        op  = rd | wr;
        err = op && ((rd && wr) || (a % 8 != 0) || (a >= 64'd1024));
        if (op) begin
            if (err) rd_exp = '0;
            else begin
                if (rd) rd_exp = mem_m[a / 8];
                else mem_m[a / 8] = d;
            end
        end
        check("addr_error", addr_error, err);
        check("pc_src", pc_src, ub | (br & z));
        check("read_data", read_data, rd_exp);
        check("stall_in_done", stall, 0);
        @(posedge clk); #1;
        mem_valid = 1'b0;
        check("done_one_cycle", done, 0);
        if (hold) begin
            @(posedge clk); #1;
            check("held_valid_no_done", done, 0);
            check("held_valid_no_stall", stall, 0);
        end
    endtask

    initial begin
        logic [63:0] a;
        logic [63:0] d;
        logic        rd;
        logic        wr;
        int          k;

        #12;
        check("reset_read_data", read_data, 0);
        check("reset_done", done, 0);
        check("reset_stall", stall, 0);
        check("reset_addr_error", addr_error, 0);
        check("reset_pc_src", pc_src, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < 128; i++) begin
            request(64'(i) * 8, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        request(64'h10, 64'hDEADBEEF_CAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        request(64'h10, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("load_0x10_value", read_data, 64'hDEADBEEF_CAFEF00D);

        request(64'h0C, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        request(64'h10, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        request(64'h400, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        request(64'h400, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        request(64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        request(64'h18, 64'h5555, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        request(64'h18, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        request(64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        request(64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        request(64'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        request(64'h8, 64'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);

        alu_result = 64'h20; read_data2 = 64'hFFFF_0000_FFFF_0000; mem_read = 1'b0; mem_write = 1'b1;
        branch = 1'b0; uncond_branch = 1'b0; zero = 1'b0; mem_valid = 1'b1;
        @(posedge clk); #1;
        mem_valid = 1'b0;
        check("busy_before_reset", stall, 1);
        rst_n = 1'b0;
        #1;
        rd_exp = '0;
        check("midrun_reset_read_data", read_data, 0);
        check("midrun_reset_pc_src", pc_src, 0);
        check("midrun_reset_stall", stall, 0);
        check("midrun_reset_done", done, 0);
        check("midrun_reset_addr_error", addr_error, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("idle_after_reset", stall, 0);
        request(64'h20, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 60; i++) begin
            k = $urandom_range(0, 3);
            case (k)
                0, 1:    a = 64'($urandom_range(0, 127)) * 8;
                2:       a = 64'($urandom_range(0, 127)) * 8 + 64'($urandom_range(1, 7));
                default: a = ($urandom_range(0, 1) == 1) ? {$urandom, $urandom} | 64'h400
                                                         : 64'h400 + 64'($urandom_range(0, 4095));
            endcase
            k = $urandom_range(0, 7);
            rd = (k < 3) || (k == 6);
            wr = ((k >= 3) && (k < 6)) || (k == 6);
            d  = {$urandom, $urandom};
            request(a, d, rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
